// File: rtl/fft_loader_if.sv
// Sample-in / RAM-write / FFT-handshake bundle for fft_loader.
// slave: the loader itself. master: whatever drives samples and owns the FFT core.
interface fft_loader_if #(
  parameter int width = 16,
  parameter int N_2   = 5
);
  logic               sample_valid;
  logic [width-1:0]   sample;
  logic               sample_ready;
  logic               fft_done;
  logic               fft_start;
  logic               load_we;
  logic [N_2-1:0]     load_adr;
  logic [2*width-1:0] load_wd;
  logic               busy;

  modport slave (
    input  sample_valid, sample, fft_done,
    output sample_ready, fft_start, load_we, load_adr, load_wd, busy
  );

  modport master (
    output sample_valid, sample, fft_done,
    input  sample_ready, fft_start, load_we, load_adr, load_wd, busy
  );
endinterface

// File: rtl/fft_loader.sv
// FFT front end: Hann-windows real samples, scales by 2^-N_2 and writes
// {re, 0} words to FFT RAM at bit-reversed addresses, then starts the FFT
// and holds off input until the FFT reports done.
module fft_loader #(
  parameter int width = 16,
  parameter int N_2   = 5
) (
  input  logic        clk,
  input  logic        reset,
  fft_loader_if.slave bus
);
  localparam int  N  = 1 << N_2;
  localparam real PI = 3.14159265358979323846;

  // Hann coefficient round(A*0.5*(1-cos(2*pi*k/N))), A = 2^(width-1)-1.
  // Angle is folded into [0, pi/2] and the quarter points are forced to an
  // exact zero so the half-way tie at k = N/4 rounds up deterministically.
  function automatic logic [width-1:0] hann_coef(input int unsigned k);
    int unsigned j;
    int unsigned r;
    logic        neg;
    real         x;
    real         c;
    real         term;
    real         amp;
    j = k % N;
    if (j <= N / 4) begin
      r = j;         neg = 1'b0;
    end else if (j <= N / 2) begin
      r = N / 2 - j; neg = 1'b1;
    end else if (j <= 3 * N / 4) begin
      r = j - N / 2; neg = 1'b1;
    end else begin
      r = N - j;     neg = 1'b0;
    end
    if (4 * r == N) begin
      c = 0.0;
    end else begin
      x    = 2.0 * PI * real'(r) / real'(N);
      term = 1.0;
      c    = 1.0;
      for (int unsigned i = 1; i <= 12; i++) begin
        term = -term * x * x / (real'(2 * i - 1) * real'(2 * i));
        c    = c + term;
      end
    end
    if (neg) c = -c;
    amp = real'((1 << (width - 1)) - 1);
    return width'($rtoi(amp * 0.5 * (1.0 - c) + 0.5));
  endfunction

  typedef enum logic [1:0] {S_LOAD, S_DRAIN, S_START, S_WAIT} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [N_2-1:0]            r_k;
  logic [1:0]                r_drain;
  logic                      w_ready;
  logic                      w_start;
  logic                      w_busy;
  logic                      w_accept;

  logic                      r_s1_v;
  logic signed [width-1:0]   r_s1_sample;
  logic [N_2-1:0]            r_s1_k;
  logic                      r_s2_v;
  logic signed [width-1:0]   r_s2_sample;
  logic [N_2-1:0]            r_s2_k;
  logic signed [width-1:0]   r_coef;

  logic                      r_we;
  logic [N_2-1:0]            r_adr;
  logic [2*width-1:0]        r_wd;

  logic [width-1:0]          w_lut [N];
  logic signed [2*width-1:0] w_product;
  logic signed [width-1:0]   w_scaled;
  logic [N_2-1:0]            w_adr_rev;

  for (genvar g = 0; g < N; g++) begin : g_lut
    localparam logic [width-1:0] COEF = hann_coef(g);
    assign w_lut[g] = COEF;
  end

  assign w_accept = bus.sample_valid && w_ready;

  // State register, sample index and drain counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_LOAD;
      r_k     <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept)
        r_k <= r_k + N_2'(1);
      else if (r_state == S_WAIT && bus.fft_done)
        r_k <= '0;
      if (r_state == S_DRAIN)
        r_drain <= r_drain + 2'd1;
      else
        r_drain <= '0;
    end
  end

  // Next state and state-decoded handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_start     = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_LOAD: begin
        w_ready = !reset;
        w_busy  = 1'b0;
        if (bus.sample_valid && r_k == N_2'(N - 1))
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_drain == 2'd2)
          w_state_nxt = S_START;
      end
      S_START: begin
        w_start     = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.fft_done)
          w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Bit-reversed RAM address of the stage-2 sample index.
  always_comb begin
    w_adr_rev = '0;
    for (int unsigned i = 0; i < N_2; i++)
      w_adr_rev[i] = r_s2_k[N_2 - 1 - i];
  end

  // Keeping product bits [2w-2:w-1] then shifting by N_2 equals one shift of
  // the whole product by w-1+N_2: bit 2w-1 always matches bit 2w-2 because
  // the coefficient never exceeds 2^(width-1)-1.
  assign w_product = r_s2_sample * r_coef;
  assign w_scaled  = width'(w_product >>> (width - 1 + N_2));

  // Two-stage window/scale pipeline feeding the registered RAM write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_v      <= 1'b0;
      r_s1_sample <= '0;
      r_s1_k      <= '0;
      r_s2_v      <= 1'b0;
      r_s2_sample <= '0;
      r_s2_k      <= '0;
      r_coef      <= '0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_wd        <= '0;
    end else begin
      r_s1_v      <= w_accept;
      r_s1_sample <= bus.sample;
      r_s1_k      <= r_k;
      r_s2_v      <= r_s1_v;
      r_s2_sample <= r_s1_sample;
      r_s2_k      <= r_s1_k;
      r_coef      <= $signed(w_lut[r_s1_k]);
      r_we        <= r_s2_v;
      if (r_s2_v) begin
        r_adr <= w_adr_rev;
        r_wd  <= {w_scaled, {width{1'b0}}};
      end
    end
  end

  assign bus.sample_ready = w_ready;
  assign bus.fft_start    = w_start;
  assign bus.busy         = w_busy;
  assign bus.load_we      = r_we;
  assign bus.load_adr     = r_adr;
  assign bus.load_wd      = r_wd;
endmodule
